alu_operand_stage: RTL

// - Execute-stage front end directly upstream of the ALU. Applies the ARM7 shifter-operand rules
//   (LSL/LSR/ASR/ROR/RRX by immediate or register, or a rotated 8-bit immediate) to produce operand_b
//   and the shifter carry-out. Registers operand_a, operand_b and the opcode into a one-entry

---
 rtl/arm_pkg.sv | 33 +++
 rtl/alu_operand_stage_if.sv | 38 +++
 rtl/barrel_shifter.sv | 140 ++++++++++++++
 rtl/alu_operand_stage.sv | 67 ++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: widths, ALU opcodes and shifter type codes.
package arm_pkg;

    localparam int DATA_W     = 32;
    localparam int RS_SHAMT_W = 8;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_EOR = 4'd1,
        ALU_SUB = 4'd2,
        ALU_RSB = 4'd3,
        ALU_ADD = 4'd4,
        ALU_ADC = 4'd5,
        ALU_SBC = 4'd6,
        ALU_RSC = 4'd7,
        ALU_TST = 4'd8,
        ALU_TEQ = 4'd9,
        ALU_CMP = 4'd10,
        ALU_CMN = 4'd11,
        ALU_ORR = 4'd12,
        ALU_MOV = 4'd13,
        ALU_BIC = 4'd14,
        ALU_MVN = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: upstream decode fields plus the valid/ready pair on each side.
interface alu_operand_stage_if;
    import arm_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     rn_data;
    logic [DATA_W-1:0]     rm_data;
    logic [RS_SHAMT_W-1:0] rs_data;
    logic [3:0]            alu_control_in;
    logic                  imm_mode;
    logic [7:0]            imm8;
    logic [3:0]            rot4;
    logic                  shift_by_reg;
    logic [1:0]            shift_type;
    logic [4:0]            shift_imm;
    logic                  carry_in;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     operand_a;
    logic [DATA_W-1:0]     operand_b;
    logic [3:0]            alu_control;
    logic                  shifter_carry_out;

    modport master (
        output in_valid, rn_data, rm_data, rs_data, alu_control_in, imm_mode,
               imm8, rot4, shift_by_reg, shift_type, shift_imm, carry_in, out_ready,
        input  in_ready, out_valid, operand_a, operand_b, alu_control, shifter_carry_out
    );

    modport slave (
        input  in_valid, rn_data, rm_data, rs_data, alu_control_in, imm_mode,
               imm8, rot4, shift_by_reg, shift_type, shift_imm, carry_in, out_ready,
        output in_ready, out_valid, operand_a, operand_b, alu_control, shifter_carry_out
    );

endinterface

// File: rtl/barrel_shifter.sv
// Combinational ARM shifter operand: immediate/register shifts, RRX and rotated immediates.
module barrel_shifter
    import arm_pkg::*;
(
    input  logic [DATA_W-1:0]     rm,
    input  logic [RS_SHAMT_W-1:0] rs,
    input  logic [4:0]            shift_imm,
    input  logic [1:0]            shift_type,
    input  logic                  by_reg,
    input  logic                  imm_mode,
    input  logic [7:0]            imm8,
    input  logic [3:0]            rot4,
    input  logic                  carry_in,
    output logic [DATA_W-1:0]     result,
    output logic                  carry
);

    shift_type_e           st;
    logic [4:0]            amt5;
    logic                  s_lo_zero;
    logic                  s_ge32;
    logic                  s_is32;
    logic                  s_zero;
    logic [DATA_W:0]       lsl_t;
    logic [DATA_W:0]       lsr_t;
    logic [DATA_W:0]       asr_t;
    logic [2*DATA_W-1:0]   ror_t;
    logic [2*DATA_W-1:0]   imm_t;
    logic [4:0]            imm_rot;

    assign st        = shift_type_e'(shift_type);
    assign amt5      = by_reg ? rs[4:0] : shift_imm;
    assign s_lo_zero = (rs[4:0] == 5'd0);
    assign s_ge32    = |rs[RS_SHAMT_W-1:5];
    assign s_is32    = (rs[RS_SHAMT_W-1:5] == (RS_SHAMT_W-5)'(1)) && s_lo_zero;
    assign s_zero    = !s_ge32 && s_lo_zero;

    // One extra bit on each shift captures the last bit shifted out (the carry).
    assign lsl_t   = {1'b0, rm} << amt5;
    assign lsr_t   = {rm, 1'b0} >> amt5;
    assign asr_t   = $signed({rm, 1'b0}) >>> amt5;
    assign ror_t   = {rm, rm} >> amt5;
    assign imm_rot = {rot4, 1'b0};
    assign imm_t   = {2{{(DATA_W-8){1'b0}}, imm8}} >> imm_rot;

    always_comb begin
        result = rm;
        carry  = carry_in;
        if (imm_mode) begin
            result = imm_t[DATA_W-1:0];
            carry  = (rot4 == 4'd0) ? carry_in : imm_t[DATA_W-1];
        end else if (!by_reg) begin
            // A zero immediate amount encodes #32 for LSR/ASR and RRX for ROR.
            case (st)
                SH_LSL: begin
                    if (amt5 != 5'd0) begin
                        result = lsl_t[DATA_W-1:0];
                        carry  = lsl_t[DATA_W];
                    end
                end
                SH_LSR: begin
                    if (amt5 == 5'd0) begin
                        result = '0;
                        carry  = rm[DATA_W-1];
                    end else begin
                        result = lsr_t[DATA_W:1];
                        carry  = lsr_t[0];
                    end
                end
                SH_ASR: begin
                    if (amt5 == 5'd0) begin
                        result = {DATA_W{rm[DATA_W-1]}};
                        carry  = rm[DATA_W-1];
                    end else begin
                        result = asr_t[DATA_W:1];
                        carry  = asr_t[0];
                    end
                end
                SH_ROR: begin
                    if (amt5 == 5'd0) begin
                        result = {carry_in, rm[DATA_W-1:1]};
                        carry  = rm[0];
                    end else begin
                        result = ror_t[DATA_W-1:0];
                        carry  = ror_t[DATA_W-1];
                    end
                end
                default: ;
            endcase
        end else if (!s_zero) begin
            case (st)
                SH_LSL: begin
                    if (s_is32) begin
                        result = '0;
                        carry  = rm[0];
                    end else if (s_ge32) begin
                        result = '0;
                        carry  = 1'b0;
                    end else begin
                        result = lsl_t[DATA_W-1:0];
                        carry  = lsl_t[DATA_W];
                    end
                end
                SH_LSR: begin
                    if (s_is32) begin
                        result = '0;
                        carry  = rm[DATA_W-1];
                    end else if (s_ge32) begin
                        result = '0;
                        carry  = 1'b0;
                    end else begin
                        result = lsr_t[DATA_W:1];
                        carry  = lsr_t[0];
                    end
                end
                SH_ASR: begin
                    if (s_ge32) begin
                        result = {DATA_W{rm[DATA_W-1]}};
                        carry  = rm[DATA_W-1];
                    end else begin
                        result = asr_t[DATA_W:1];
                        carry  = asr_t[0];
                    end
                end
                SH_ROR: begin
                    // Rotating by a multiple of 32 leaves rm but still reports rm[31].
                    if (s_lo_zero) begin
                        result = rm;
                        carry  = rm[DATA_W-1];
                    end else begin
                        result = ror_t[DATA_W-1:0];
                        carry  = ror_t[DATA_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-stage front end: shifter operand generation into a one-entry valid/ready register feeding the ALU.
module alu_operand_stage
    import arm_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    alu_operand_stage_if.slave bus
);

    logic [DATA_W-1:0] shift_result;
    logic              shift_carry;
    logic              accept;
    logic              in_ready;

    logic              out_valid_q;
    logic [DATA_W-1:0] operand_a_q;
    logic [DATA_W-1:0] operand_b_q;
    logic [3:0]        alu_control_q;
    logic              carry_q;

    barrel_shifter u_shifter (
        .rm        (bus.rm_data),
        .rs        (bus.rs_data),
        .shift_imm (bus.shift_imm),
        .shift_type(bus.shift_type),
        .by_reg    (bus.shift_by_reg),
        .imm_mode  (bus.imm_mode),
        .imm8      (bus.imm8),
        .rot4      (bus.rot4),
        .carry_in  (bus.carry_in),
        .result    (shift_result),
        .carry     (shift_carry)
    );

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Flush wins over a same-cycle accept; data registers only move on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q   <= 1'b0;
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            alu_control_q <= '0;
            carry_q       <= 1'b0;
        end else if (flush) begin
            out_valid_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            operand_a_q   <= bus.rn_data;
            operand_b_q   <= shift_result;
            alu_control_q <= bus.alu_control_in;
            carry_q       <= shift_carry;
        end else if (bus.out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.out_valid         = out_valid_q;
    assign bus.operand_a         = operand_a_q;
    assign bus.operand_b         = operand_b_q;
    assign bus.alu_control       = alu_control_q;
    assign bus.shifter_carry_out = carry_q;

endmodule
